pim_arbiter: RTL and testbench

PIM_ARBITER -- requirements
Module: pim_arbiter

---
 rtl/pim_arbiter.sv | 151 +++++++++++++++
 tb/tb_pim_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pim_arbiter.sv
// pim_arbiter: two-master round-robin arbiter in front of a single-port PIM
// macro. At most one access is in flight; a read returns its data RD_LAT
// cycles after the PIM strobe, and a write returns to idle right after its strobe.
module pim_arbiter #(
  parameter int XLEN   = 32,
  parameter int RD_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            m0_req_i,
  input  logic            m0_we_i,
  input  logic [XLEN-1:0] m0_addr_i,
  input  logic [XLEN-1:0] m0_wdata_i,
  input  logic            m1_req_i,
  input  logic            m1_we_i,
  input  logic [XLEN-1:0] m1_addr_i,
  input  logic [XLEN-1:0] m1_wdata_i,
  output logic            m0_gnt_o,
  output logic            m1_gnt_o,
  output logic            m0_rvalid_o,
  output logic            m1_rvalid_o,
  output logic [XLEN-1:0] m0_rdata_o,
  output logic [XLEN-1:0] m1_rdata_o,
  output logic            pim_en_o,
  output logic            pim_we_o,
  output logic [XLEN-1:0] pim_addr_o,
  output logic [XLEN-1:0] pim_wd_o,
  input  logic [XLEN-1:0] pim_rd_i,
  output logic            busy_o
);

  // state   | meaning
  // IDLE    | no access in flight; grant combinationally to a requester
  // ISSUE   | PIM strobe for the captured access (one cycle)
  // WAIT    | read latency countdown; sample pim_rd_i when count hits 0
  // RESP    | read-data-valid pulse to the owning master (one cycle)

  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("pim_arbiter: RD_LAT must be in 1..8");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [2:0] CNT_LOAD = 3'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            prio_q, prio_d;    // 1: m1 wins a tie
  logic            owner_q, owner_d;  // 1: access belongs to m1
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            gnt0, gnt1;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (gnt0 || gnt1) state_d = S_ISSUE;
      S_ISSUE: state_d = we_q ? S_IDLE : S_WAIT;
      S_WAIT:  if (cnt_q == 3'd0) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: grants only in IDLE and never while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == S_IDLE && !rst_i) begin
      if (m0_req_i && (!m1_req_i || !prio_q)) gnt0 = 1'b1;
      else if (m1_req_i)                      gnt1 = 1'b1;
    end
    m0_gnt_o    = gnt0;
    m1_gnt_o    = gnt1;
    pim_en_o    = (state_q == S_ISSUE);
    pim_we_o    = (state_q == S_ISSUE) && we_q;
    m0_rvalid_o = (state_q == S_RESP) && !owner_q;
    m1_rvalid_o = (state_q == S_RESP) && owner_q;
    busy_o      = (state_q != S_IDLE);
  end

  assign pim_addr_o = addr_q;
  assign pim_wd_o   = wd_q;
  assign m0_rdata_o = rdata_q;
  assign m1_rdata_o = rdata_q;

  // Datapath next values: capture on grant, load/decrement latency counter, sample read data.
  always_comb begin
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (gnt0) begin
          owner_d = 1'b0;
          prio_d  = 1'b1;
          we_d    = m0_we_i;
          addr_d  = m0_addr_i;
          wd_d    = m0_wdata_i;
        end else if (gnt1) begin
          owner_d = 1'b1;
          prio_d  = 1'b0;
          we_d    = m1_we_i;
          addr_d  = m1_addr_i;
          wd_d    = m1_wdata_i;
        end
      end
      S_ISSUE: if (!we_q) cnt_d = CNT_LOAD;
      S_WAIT: begin
        if (cnt_q == 3'd0) rdata_d = pim_rd_i;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears everything so an aborted read leaves no trace.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 3'd0;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_pim_arbiter.sv
// Bench for pim_arbiter: timeline model of transactions for the RD_LAT=2
// instance, plus directed literal expectations including RD_LAT=1/8 instances.
module tb_pim_arbiter;

  localparam int XLEN = 32;
  localparam int LAT  = 2;

  logic clk = 1'b0;
  logic rst;
  logic m0_req, m0_we, m1_req, m1_we;
  logic [XLEN-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata, pim_rd;

  logic m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, pim_en, pim_we, busy;
  logic [XLEN-1:0] m0_rdata, m1_rdata, pim_addr, pim_wd;

  logic d1_m0_gnt, d1_m1_gnt, d1_m0_rvalid, d1_m1_rvalid, d1_pim_en, d1_pim_we, d1_busy;
  logic [XLEN-1:0] d1_m0_rdata, d1_m1_rdata, d1_pim_addr, d1_pim_wd;
  logic d8_m0_gnt, d8_m1_gnt, d8_m0_rvalid, d8_m1_rvalid, d8_pim_en, d8_pim_we, d8_busy;
  logic [XLEN-1:0] d8_m0_rdata, d8_m1_rdata, d8_pim_addr, d8_pim_wd;

  always #5 clk = ~clk;

  pim_arbiter #(.XLEN(XLEN), .RD_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt), .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
    .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata), .pim_en_o(pim_en), .pim_we_o(pim_we),
    .pim_addr_o(pim_addr), .pim_wd_o(pim_wd), .pim_rd_i(pim_rd), .busy_o(busy)
  );

  pim_arbiter #(.XLEN(XLEN), .RD_LAT(1)) dut_lat1 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(d1_m0_gnt), .m1_gnt_o(d1_m1_gnt), .m0_rvalid_o(d1_m0_rvalid), .m1_rvalid_o(d1_m1_rvalid),
    .m0_rdata_o(d1_m0_rdata), .m1_rdata_o(d1_m1_rdata), .pim_en_o(d1_pim_en), .pim_we_o(d1_pim_we),
    .pim_addr_o(d1_pim_addr), .pim_wd_o(d1_pim_wd), .pim_rd_i(pim_rd), .busy_o(d1_busy)
  );

  pim_arbiter #(.XLEN(XLEN), .RD_LAT(8)) dut_lat8 (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m0_gnt_o(d8_m0_gnt), .m1_gnt_o(d8_m1_gnt), .m0_rvalid_o(d8_m0_rvalid), .m1_rvalid_o(d8_m1_rvalid),
    .m0_rdata_o(d8_m0_rdata), .m1_rdata_o(d8_m1_rdata), .pim_en_o(d8_pim_en), .pim_we_o(d8_pim_we),
    .pim_addr_o(d8_pim_addr), .pim_wd_o(d8_pim_wd), .pim_rd_i(pim_rd), .busy_o(d8_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Literal expectations: at cycle 'cyc', signal 'id' must equal 'val'.
  typedef struct {
    int          cyc;
    int          id;
    logic [31:0] val;
  } lit_t;
  lit_t lits[$];

  task automatic expect_at(input int c, input int id, input logic [31:0] v);
    lit_t e;
    e.cyc = c;
    e.id  = id;
    e.val = v;
    lits.push_back(e);
  endtask

  function automatic string lit_name(input int id);
    case (id)
      0: return "lit:m0_gnt";      1: return "lit:m1_gnt";
      2: return "lit:pim_en";      3: return "lit:pim_we";
      4: return "lit:pim_addr";    5: return "lit:pim_wd";
      6: return "lit:m0_rvalid";   7: return "lit:m1_rvalid";
      8: return "lit:m0_rdata";    9: return "lit:busy";
      10: return "lit:lat1_m0_rvalid"; 11: return "lit:lat8_m0_rvalid";
      12: return "lit:lat1_rdata";     13: return "lit:lat8_rdata";
      14: return "lit:m1_rdata";
      default: return "lit:unknown";
    endcase
  endfunction

  function automatic logic [31:0] lit_actual(input int id);
    case (id)
      0: return 32'(m0_gnt);      1: return 32'(m1_gnt);
      2: return 32'(pim_en);      3: return 32'(pim_we);
      4: return pim_addr;         5: return pim_wd;
      6: return 32'(m0_rvalid);   7: return 32'(m1_rvalid);
      8: return m0_rdata;         9: return 32'(busy);
      10: return 32'(d1_m0_rvalid); 11: return 32'(d8_m0_rvalid);
      12: return d1_m0_rdata;       13: return d8_m0_rdata;
      14: return m1_rdata;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
  endtask

  // Transaction timeline model: grant at T, strobe at T+1, read data sampled
  // at T+LAT+1, rvalid at T+LAT+2, arbiter free again at m_free.
  int          m_free;
  bit          tx_valid;
  int          tx_t;
  bit          tx_m;
  bit          tx_we;
  bit          m_last;
  logic [31:0] m_addr, m_wd, m_rdata;
  bit          e_g0, e_g1, e_en;

  initial begin
    m_free = 0; tx_valid = 0; tx_t = 0; tx_m = 0; tx_we = 0; m_last = 1;
    m_addr = 0; m_wd = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("mdl:rst_m0_gnt", 32'(m0_gnt), 0);
        check("mdl:rst_m1_gnt", 32'(m1_gnt), 0);
        check("mdl:rst_pim_en", 32'(pim_en), 0);
        check("mdl:rst_pim_we", 32'(pim_we), 0);
        check("mdl:rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 0);
        check("mdl:rst_busy", 32'(busy), 0);
        check("mdl:rst_pim_addr", pim_addr, 0);
        check("mdl:rst_pim_wd", pim_wd, 0);
        check("mdl:rst_rdata", m0_rdata, 0);
        m_free = 0; tx_valid = 0; m_last = 1;
        m_addr = 0; m_wd = 0; m_rdata = 0;
      end else begin
        e_g0 = 0;
        e_g1 = 0;
        if (cyc >= m_free) begin
          if (m0_req && m1_req) begin
            if (m_last == 0) e_g1 = 1; else e_g0 = 1;
          end else if (m0_req) e_g0 = 1;
          else if (m1_req)     e_g1 = 1;
        end
        e_en = tx_valid && (cyc == tx_t + 1);
        check("mdl:m0_gnt", 32'(m0_gnt), 32'(e_g0));
        check("mdl:m1_gnt", 32'(m1_gnt), 32'(e_g1));
        check("mdl:pim_en", 32'(pim_en), 32'(e_en));
        check("mdl:pim_we", 32'(pim_we), 32'(e_en && tx_we));
        check("mdl:pim_addr", pim_addr, m_addr);
        check("mdl:pim_wd", pim_wd, m_wd);
        check("mdl:m0_rvalid", 32'(m0_rvalid),
              32'(tx_valid && !tx_we && tx_m == 0 && cyc == tx_t + LAT + 2));
        check("mdl:m1_rvalid", 32'(m1_rvalid),
              32'(tx_valid && !tx_we && tx_m == 1 && cyc == tx_t + LAT + 2));
        check("mdl:m0_rdata", m0_rdata, m_rdata);
        check("mdl:m1_rdata", m1_rdata, m_rdata);
        check("mdl:busy", 32'(busy), 32'(cyc < m_free));
        if (tx_valid && !tx_we && cyc == tx_t + LAT + 1) m_rdata = pim_rd;
        if (e_g0 || e_g1) begin
          tx_valid = 1;
          tx_t     = cyc;
          tx_m     = e_g1;
          tx_we    = e_g1 ? m1_we : m0_we;
          m_addr   = e_g1 ? m1_addr : m0_addr;
          m_wd     = e_g1 ? m1_wdata : m0_wdata;
          m_free   = cyc + (tx_we ? 2 : LAT + 3);
          m_last   = e_g1;
        end
      end
      foreach (lits[i])
        if (lits[i].cyc == cyc) check(lit_name(lits[i].id), lit_actual(lits[i].id), lits[i].val);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t;

  initial begin
    rst = 1; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; pim_rd = 0;
    step(3);
    rst = 0;
    step(1);

    // m0 read at 0x10
    t = cyc;
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; pim_rd = 32'hDEAD_0000;
    expect_at(t, 0, 1);       expect_at(t, 1, 0);
    expect_at(t + 1, 2, 1);   expect_at(t + 1, 3, 0);   expect_at(t + 1, 4, 32'h10);
    expect_at(t + 3, 6, 0);   expect_at(t + 4, 6, 1);   expect_at(t + 4, 7, 0);
    expect_at(t + 4, 8, 32'hCAFE_F00D); expect_at(t + 4, 14, 32'hCAFE_F00D);
    expect_at(t + 4, 9, 1);   expect_at(t + 5, 9, 0);
    step(1); m0_req = 0;
    step(2); pim_rd = 32'hCAFE_F00D;
    step(1); pim_rd = 32'hDEAD_0000;
    step(1);

    // m1 write, then m0 read queued behind the write strobe
    t = cyc;
    m1_req = 1; m1_we = 1; m1_addr = 32'h20; m1_wdata = 32'h1234_5678;
    expect_at(t, 1, 1);       expect_at(t, 0, 0);
    expect_at(t + 1, 2, 1);   expect_at(t + 1, 3, 1);   expect_at(t + 1, 4, 32'h20);
    expect_at(t + 1, 5, 32'h1234_5678); expect_at(t + 1, 9, 1); expect_at(t + 1, 7, 0);
    expect_at(t + 1, 0, 0);
    expect_at(t + 2, 2, 0);   expect_at(t + 2, 3, 0);   expect_at(t + 2, 4, 32'h20);
    expect_at(t + 2, 8, 32'hCAFE_F00D); expect_at(t + 2, 0, 1);
    expect_at(t + 3, 7, 0);
    step(1); m1_req = 0; m1_we = 0; m0_req = 1; m0_addr = 32'h30;
    step(2); m0_req = 0;
    step(4);

    // both masters reading continuously from reset
    rst = 1;
    step(1);
    rst = 0;
    t = cyc;
    m0_req = 1; m1_req = 1; m0_we = 0; m1_we = 0; m0_addr = 32'h100; m1_addr = 32'h200;
    expect_at(t, 0, 1);       expect_at(t, 1, 0);
    expect_at(t + 2, 0, 0);   expect_at(t + 2, 1, 0);
    expect_at(t + 4, 6, 1);   expect_at(t + 4, 7, 0);
    expect_at(t + 4, 8, 32'hA500_0000 + 32'(t + 3));
    expect_at(t + 5, 1, 1);   expect_at(t + 5, 0, 0);   expect_at(t + 6, 4, 32'h200);
    expect_at(t + 9, 7, 1);   expect_at(t + 9, 6, 0);
    expect_at(t + 10, 0, 1);  expect_at(t + 11, 4, 32'h100); expect_at(t + 15, 1, 1);
    for (int i = 0; i < 16; i++) begin
      pim_rd = 32'hA500_0000 + 32'(cyc);
      step(1);
    end
    m0_req = 0; m1_req = 0;
    step(4);

    // m0 holds its request through an m1 read
    t = cyc;
    m1_req = 1; m1_addr = 32'h300;
    expect_at(t, 1, 1);       expect_at(t + 1, 0, 0);   expect_at(t + 3, 0, 0);
    expect_at(t + 4, 0, 0);   expect_at(t + 4, 7, 1);   expect_at(t + 5, 0, 1);
    expect_at(t + 5, 1, 0);
    step(1); m1_req = 0; m0_req = 1; m0_addr = 32'h400;
    step(5); m0_req = 0;
    step(4);

    // reset during WAIT, then a tie resolves to m0 again
    t = cyc;
    m0_req = 1; m0_addr = 32'h500;
    step(1); m0_req = 0;
    step(1); rst = 1;
    expect_at(t + 2, 9, 0);   expect_at(t + 2, 4, 0);   expect_at(t + 2, 8, 0);
    expect_at(t + 3, 9, 0);
    step(1);
    step(1); rst = 0;
    expect_at(t + 4, 6, 0);   expect_at(t + 5, 6, 0);   expect_at(t + 4, 8, 0);
    expect_at(t + 4, 9, 0);
    expect_at(t + 6, 0, 1);   expect_at(t + 6, 1, 0);   expect_at(t + 11, 1, 1);
    step(2);
    m0_req = 1; m1_req = 1; m0_addr = 32'h600; m1_addr = 32'h700;
    step(1); m0_req = 0;
    step(5); m1_req = 0;
    step(4);

    // latency sweep across RD_LAT=1/2/8 instances
    rst = 1;
    step(1);
    rst = 0;
    t = cyc;
    m0_req = 1; m0_addr = 32'h800; pim_rd = 32'h5A5A_0001;
    expect_at(t + 2, 10, 0);  expect_at(t + 3, 10, 1);  expect_at(t + 3, 12, 32'h5A5A_0001);
    expect_at(t + 9, 11, 0);  expect_at(t + 10, 11, 1); expect_at(t + 10, 13, 32'h5A5A_0001);
    expect_at(t + 4, 6, 1);
    step(1); m0_req = 0;
    step(13);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
